// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder: DIRECT decodes din with 1-cycle latency at full rate (din_ready = en & ~mode), SCAN walks lines holding each DWELL cycles.
// Optional DECODER_SCAN_WRAP_EN adds scan_wrap, a one-cycle pulse on the edge where the scan index wraps to 0.
module decoder_scan #(
  parameter int N_IN  = 3,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [N_IN-1:0]      din,
  output logic [2**N_IN-1:0]   dout,
  output logic                 dout_valid,
  output logic [N_IN-1:0]      idx
`ifdef DECODER_SCAN_WRAP_EN
  ,
  output logic                 scan_wrap
`endif
);

  localparam int OW = 2**N_IN;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [N_IN-1:0] idx_nxt;
  logic [OW-1:0]   dout_nxt;
  logic            valid_nxt;
  logic            xfer;
  logic            last_dwell;

  assign din_ready  = en & ~mode;
  assign xfer       = din_valid & din_ready;
  assign last_dwell = (cnt == CW'(DWELL - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    dout_nxt  = dout;
    valid_nxt = dout_valid;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      dout_nxt  = '0;
      valid_nxt = 1'b0;
    end else if (!mode) begin
      state_nxt = DIRECT;
      cnt_nxt   = '0;
      // A transfer on the entry edge wins over the entry clear.
      if (xfer) begin
        idx_nxt   = din;
        dout_nxt  = OW'(1) << din;
        valid_nxt = 1'b1;
      end else if (state != DIRECT) begin
        idx_nxt   = '0;
        dout_nxt  = '0;
        valid_nxt = 1'b0;
      end
    end else begin
      state_nxt = SCAN;
      valid_nxt = 1'b1;
      if (state != SCAN) begin
        cnt_nxt  = '0;
        idx_nxt  = '0;
        dout_nxt = OW'(1);
      end else if (last_dwell) begin
        cnt_nxt  = '0;
        idx_nxt  = idx + N_IN'(1);
        dout_nxt = OW'(1) << idx_nxt;
      end else begin
        cnt_nxt  = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      dout       <= dout_nxt;
      dout_valid <= valid_nxt;
    end
  end

`ifdef DECODER_SCAN_WRAP_EN
  // Only a continuing scan can wrap; the entry edge lands on line 0 without wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scan_wrap <= 1'b0;
    else
      scan_wrap <= en & mode & (state == SCAN) & last_dwell & (idx == N_IN'(OW - 1));
  end
`endif

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: three configurations driven in parallel, checked by a scoreboard fed from a time-based reference model.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, mode, din_valid;
  logic [2:0] din;

  logic       rdy0, rdy1, rdy2;
  logic [7:0] dout0;
  logic [3:0] dout1;
  logic [1:0] dout2;
  logic       v0, v1, v2;
  logic [2:0] idx0;
  logic [1:0] idx1;
  logic [0:0] idx2;
`ifdef DECODER_SCAN_WRAP_EN
  logic       sw0, sw1, sw2;
`endif

  always #5 clk = ~clk;

  decoder_scan #(.N_IN(3), .DWELL(4)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din_valid(din_valid),
    .din_ready(rdy0), .din(din), .dout(dout0), .dout_valid(v0), .idx(idx0)
`ifdef DECODER_SCAN_WRAP_EN
    , .scan_wrap(sw0)
`endif
  );

  decoder_scan #(.N_IN(2), .DWELL(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din_valid(din_valid),
    .din_ready(rdy1), .din(din[1:0]), .dout(dout1), .dout_valid(v1), .idx(idx1)
`ifdef DECODER_SCAN_WRAP_EN
    , .scan_wrap(sw1)
`endif
  );

  decoder_scan #(.N_IN(1), .DWELL(3)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din_valid(din_valid),
    .din_ready(rdy2), .din(din[0:0]), .dout(dout2), .dout_valid(v2), .idx(idx2)
`ifdef DECODER_SCAN_WRAP_EN
    , .scan_wrap(sw2)
`endif
  );

  typedef struct packed {
    logic [2:0][7:0] dout;
    logic [2:0]      valid;
    logic [2:0][2:0] idx;
    logic [2:0]      wrap;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: per instance, activity kind plus either the last code or the time since scan entry.
  int nw[3] = '{3, 2, 1};
  int dw[3] = '{4, 1, 3};
  int m_st[3];     // 0 idle, 1 direct, 2 scan
  int m_code[3];
  int m_valid[3];
  int m_t[3];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          m_st[i] = 0; m_code[i] = 0; m_valid[i] = 0; m_t[i] = 0;
        end
      end else begin
        exp_t e;
        e = '0;
        for (int i = 0; i < 3; i++) begin
          int lines;
          lines = 1 << nw[i];
          if (!en) begin
            m_st[i] = 0; m_valid[i] = 0; m_code[i] = 0;
          end else if (!mode) begin
            if (m_st[i] != 1) begin m_valid[i] = 0; m_code[i] = 0; end
            m_st[i] = 1;
            if (din_valid) begin m_code[i] = int'(din) % lines; m_valid[i] = 1; end
          end else begin
            if (m_st[i] != 2) m_t[i] = 0;
            else begin
              m_t[i] = m_t[i] + 1;
              if (m_t[i] % (dw[i] * lines) == 0) e.wrap[i] = 1'b1;
            end
            m_st[i] = 2;
            m_valid[i] = 1;
            m_code[i] = (m_t[i] / dw[i]) % lines;
          end
          e.dout[i]  = (m_valid[i] != 0) ? 8'(1 << m_code[i]) : 8'h00;
          e.valid[i] = (m_valid[i] != 0);
          e.idx[i]   = 3'(m_code[i]);
        end
        q.push_back(e);
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%h exp=%h", nm, i, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents a registered selection every cycle; compare on the falling edge.
  exp_t cur;
  initial begin
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        cur = '0;
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end
      chk("dout",  0, dout0, cur.dout[0]);
      chk("dout",  1, {4'h0, dout1}, cur.dout[1]);
      chk("dout",  2, {6'h0, dout2}, cur.dout[2]);
      chk("valid", 0, {7'h0, v0}, {7'h0, cur.valid[0]});
      chk("valid", 1, {7'h0, v1}, {7'h0, cur.valid[1]});
      chk("valid", 2, {7'h0, v2}, {7'h0, cur.valid[2]});
      chk("idx",   0, {5'h0, idx0}, {5'h0, cur.idx[0]});
      chk("idx",   1, {6'h0, idx1}, {5'h0, cur.idx[1]});
      chk("idx",   2, {7'h0, idx2}, {5'h0, cur.idx[2]});
      chk("ready", 0, {5'h0, rdy2, rdy1, rdy0}, {5'h0, {3{en & ~mode}}});
`ifdef DECODER_SCAN_WRAP_EN
      chk("wrap",  0, {5'h0, sw2, sw1, sw0}, {5'h0, cur.wrap});
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; din_valid = 1'b0; din = 3'd0;
    tick(3);
    rst = 1'b0;
    tick(3);

    // DIRECT sweep then hold
    en = 1'b1; mode = 1'b0; din_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      din = 3'(c);
      tick(1);
    end
    din_valid = 1'b0;
    tick(3);

    // SCAN dwell and wrap
    mode = 1'b1;
    tick(40);

    // Mode switch mid-dwell at idx 3, then a transfer of code 6
    en = 1'b0; tick(1);
    en = 1'b1; mode = 1'b1; tick(14);
    mode = 1'b0; tick(1);
    din = 3'd6; din_valid = 1'b1; tick(1);
    din_valid = 1'b0; tick(2);

    // Enable falls together with a valid code
    din = 3'd2; din_valid = 1'b1; en = 1'b0; tick(1);
    din_valid = 1'b0; tick(2);

    // Reset while scanning at idx 5, then stay disabled
    en = 1'b1; mode = 1'b1; tick(21);
    rst = 1'b1; tick(2);
    rst = 1'b0; en = 1'b0; tick(3);

    // Randomised segments
    for (int s = 0; s < 80; s++) begin
      int len;
      en   = ($urandom_range(0, 7) != 0);
      mode = ($urandom_range(0, 2) == 0);
      len  = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        din       = 3'($urandom_range(0, 7));
        din_valid = $urandom_range(0, 1) != 0;
        if ($urandom_range(0, 199) == 0) rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end

    en = 1'b0; din_valid = 1'b0;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
Name: decoder_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; next generation of the combinational 3-to-8 decoder.
- Two modes:
  - DIRECT: decodes handshaked input codes.
  - SCAN: autonomously walks the one-hot output through every line, holding each for a programmable dwell time.
- Sits between control logic and row/digit-select or chip-select fan-out, where glitch-free registered selects are required.

Parameters:
- N_IN, 3, input code width; legal range 1..8; output width is 2**N_IN.
- DWELL, 4, clock cycles each output line stays active in SCAN; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  block enable; low forces idle.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- din_valid  input  1  din carries a code to decode.
- din_ready  output  1  block accepts din this cycle.
- din  input  N_IN  code to decode (bit 0 = LSB).
- dout  output  2**N_IN  registered one-hot select; bit k active for code k.
- dout_valid  output  1  dout holds a valid selection.
- idx  output  N_IN  binary index of the active dout bit.

Behaviour:
- Reset (async assert, sync release):
  - dout=0, dout_valid=0, idx=0, dwell counter=0, state=IDLE.
  - rst mid-operation clears everything immediately, regardless of state or handshake.
- States are IDLE, DIRECT and SCAN. State, dout, dout_valid and idx are registered. din_ready is combinational: en & ~mode.
- Transitions, evaluated each edge:
  - en=0 -> IDLE.
  - en=1 & mode=0 -> DIRECT.
  - en=1 & mode=1 -> SCAN.
- IDLE:
  - dout=0, dout_valid=0, idx=0, dwell counter=0.
  - Outputs clear on the first edge where en is sampled low.
- DIRECT:
  - Handshake: transfer when din_valid & din_ready at the edge.
  - Latency 1: the edge after transfer gives dout = 1<<din, idx = din, dout_valid=1.
  - Without a transfer, dout, idx and dout_valid hold their last values.
  - Back-to-back transfers every cycle are supported (full throughput).
  - On first entry from IDLE or SCAN: dout=0, dout_valid=0 until the first transfer.
- SCAN:
  - din_ready=0; din is ignored.
  - Entry edge: idx=0, dwell counter=0, dout=1 (bit 0), dout_valid=1.
  - The dwell counter increments each cycle.
  - When the counter equals DWELL-1: counter returns to 0, idx advances by 1 modulo 2**N_IN, dout = 1<<(new idx).
  - Wrap-around: idx goes from 2**N_IN-1 to 0.
  - Each line is active for exactly DWELL cycles. DWELL=1 advances every cycle.
- Mode switch SCAN->DIRECT mid-dwell: counter is discarded; DIRECT entry rules apply.
- Simultaneous en fall and din_valid: en wins; no transfer; IDLE.
- dout is always one-hot when dout_valid=1, and all-zero when dout_valid=0.
- Width rules:
  - Dwell counter width is clog2(DWELL) bits, minimum 1.
  - idx increment is N_IN-bit modulo arithmetic.

Optional Feature:
- Macro DECODER_SCAN_WRAP_EN.
- Defined:
  - Adds output port scan_wrap (1 bit, reset 0), registered.
  - Pulses high for exactly one cycle, coincident with the edge where idx wraps 2**N_IN-1 -> 0 in SCAN.
  - Never asserts in DIRECT or IDLE, or on SCAN entry.
- Undefined: port absent; no other behaviour change.

Test Plan:
1. Reset/idle: assert rst mid-SCAN with idx=5 -> dout=0, dout_valid=0, idx=0 immediately; en=0 after release -> outputs stay 0.
2. DIRECT sweep (N_IN=3): en=1, mode=0, din=0..7 with din_valid every cycle -> one cycle later dout=01,02,04,...,80 hex, idx=din, dout_valid=1; din_valid low -> last dout (80) held.
3. SCAN dwell/wrap (N_IN=3, DWELL=4): en=1, mode=1 for 40 cycles -> dout=01 for 4 cycles, then 02, ..., 80, then 01 at cycle 32; din_ready=0 throughout; with DECODER_SCAN_WRAP_EN, scan_wrap is a single pulse at cycle 32.
4. Mode switch: SCAN at idx=3 mid-dwell, mode->0 -> next edge dout=0, dout_valid=0; din=6 transfer -> dout=40, idx=6.
5. Enable precedence: DIRECT with din_valid=1, din=2 and en falling the same cycle -> no transfer; next edge dout=0, dout_valid=0.
6. DWELL=1, N_IN=2: SCAN -> dout cycles 1,2,4,8,1 every clock; N_IN=1 DIRECT din=1 -> dout=2.
